ins_cache: RTL and testbench
============================

INS_CACHE -- requirements
Module: ins_cache

Interface
REQ-001 The block SHALL be parameterised as follows:
- LINES, 16, number of direct-mapped one-word lines; power of two.
- INDEX_W, 4, log2(LINES).
REQ-002 The block SHALL have the following ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- rdy  in  1  global ready; low freezes all state.
- req_from_if  in  1  fetch request; held by the fetcher until ins_valid or flush.
- pc_from_if  in  32  fetch address; stable while req_from_if is high.
- flush  in  1  abort the current fetch (branch redirect).
- ins_valid  out  1  one-cycle pulse; ins_out is valid.
- ins_out  out  32  fetched instruction word.
- mem_req  out  1  level request to the memory controller.
- mem_addr  out  32  word address to the memory controller.
- mem_ok  in  1  one-cycle pulse; mem_ins is valid.
- mem_ins  in  32  instruction word from the memory controller.

Function
REQ-003 Address split SHALL be: index = pc[INDEX_W+1:2]; tag = pc[31:INDEX_W+2]; pc[1:0] ignored.
REQ-004 Storage SHALL be LINES entries, each holding a valid bit, a tag and a 32-bit data word.
REQ-005 The state machine SHALL have three states: IDLE, MISS, RESP.
REQ-006 IDLE with req_from_if=1, flush=0 and a hit (valid bit set and tag equal): the block SHALL drive ins_out=data and pulse ins_valid in the next cycle, then go to RESP.
REQ-007 IDLE with req_from_if=1, flush=0 and a miss: the block SHALL go to MISS with mem_req=1 and mem_addr={pc[31:2],2'b00} from the next cycle.
REQ-008 MISS: mem_req and mem_addr SHALL hold until mem_ok is sampled high.
REQ-009 At the edge where mem_ok is sampled high in MISS, the block SHALL:
- write the line (valid=1, tag, mem_ins);
- set ins_out=mem_ins and pulse ins_valid;
- drop mem_req to 0;
- go to RESP.
REQ-010 Dropping mem_req at the mem_ok edge SHALL ensure the controller never sees a stale request and restarts.
REQ-011 RESP SHALL deassert ins_valid and return to IDLE unconditionally; a new request is accepted one cycle later.
REQ-012 Hit latency SHALL be 1 cycle. Miss latency SHALL be 1 cycle plus the controller latency plus 1 cycle.
REQ-013 flush=1 in any state SHALL force IDLE and mem_req=0 next cycle, with no ins_valid. Dropping mem_req mid-miss is the controller's abort signal.
REQ-014 flush and mem_ok in the same cycle: flush SHALL win for ins_valid (no pulse), but the line SHALL still be written.
REQ-015 flush SHALL NOT clear valid bits.
REQ-016 flush and req_from_if in the same cycle in IDLE: the request SHALL be ignored.
REQ-017 rdy=0 SHALL freeze the state, the storage and all outputs. A mem_ok pulse arriving while rdy=0 is the system's responsibility to avoid.
REQ-018 ins_valid SHALL never be high for two consecutive cycles.

Reset
REQ-019 On rst=1 at a clock edge, the block SHALL set: state=IDLE, all valid bits=0, ins_valid=0, ins_out=0, mem_req=0, mem_addr=0.
REQ-020 Reset during MISS SHALL drop mem_req the next cycle; no line SHALL be written.
REQ-021 rst SHALL take priority over rdy and flush.

Configuration
REQ-022 Macro ICACHE_EN defined: the block SHALL behave as specified above.
REQ-023 Macro ICACHE_EN undefined: storage SHALL be omitted and every request SHALL be treated as a miss; the handshake, latency and flush rules SHALL be otherwise identical.

Verification
REQ-024 Cold fetch: reset; req pc=0x00000010; mem_ok with mem_ins=0x00100093 after 5 cycles. Required: mem_addr=0x10; ins_valid one cycle later with ins_out=0x00100093; mem_req low at that same edge.
REQ-025 Warm hit: repeat pc=0x10 after REQ-024. Required: mem_req stays 0; ins_valid the next cycle with 0x00100093.
REQ-026 Conflict: fetch pc=0x10, then pc=0x50 (same index 4, different tag). Required: second fetch misses. Then fetch pc=0x10 again. Required: misses again.
REQ-027 Flush mid-miss: flush at cycle 3 of a miss. Required: mem_req=0 next cycle; no ins_valid; the same pc refetched misses.
REQ-028 Flush coincident with mem_ok: no ins_valid. Then refetch the same pc. Required: hit.
REQ-029 rdy low for 4 cycles during MISS: state and mem_addr unchanged; completion resumes after rdy rises.

Source files
------------

// File: rtl/ins_cache.sv
// Direct-mapped, one-word-per-line instruction cache sitting between the fetch
// unit and the memory controller. Define ICACHE_EN to build the storage; without it every fetch misses.
module ins_cache #(
  parameter int LINES   = 16,
  parameter int INDEX_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        req_from_if,
  input  logic [31:0] pc_from_if,
  input  logic        flush,
  output logic        ins_valid,
  output logic [31:0] ins_out,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ok,
  input  logic [31:0] mem_ins,
  output logic [1:0]  state_dbg
);

  // Handshake: req_from_if is held by the fetcher until ins_valid (one-cycle
  // pulse) or flush; mem_req is a level held until mem_ok (one-cycle pulse).
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MISS = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int TAG_W = 32 - INDEX_W - 2;

  state_t      state, state_n;
  logic        ins_valid_n;
  logic [31:0] ins_out_n;
  logic        mem_req_n;
  logic [31:0] mem_addr_n;
  logic        hit;
  logic [31:0] hit_data;
  logic        fill;

  // A line is filled whenever the controller answers, even if a flush
  // arrives in the same cycle.
  assign fill = (state == MISS) && mem_ok;

`ifdef ICACHE_EN
  logic [INDEX_W-1:0] pc_index;
  logic [TAG_W-1:0]   pc_tag;
  logic [INDEX_W-1:0] miss_index;
  logic [TAG_W-1:0]   miss_tag;
  logic [LINES-1:0]   valid_q;
  logic [TAG_W-1:0]   tag_q  [LINES];
  logic [31:0]        data_q [LINES];

  assign pc_index   = pc_from_if[INDEX_W+1:2];
  assign pc_tag     = pc_from_if[31:INDEX_W+2];
  assign miss_index = mem_addr[INDEX_W+1:2];
  assign miss_tag   = mem_addr[31:INDEX_W+2];
  assign hit        = valid_q[pc_index] && (tag_q[pc_index] == pc_tag);
  assign hit_data   = data_q[pc_index];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (rdy && fill) begin
      valid_q[miss_index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && rdy && fill) begin
      tag_q[miss_index]  <= miss_tag;
      data_q[miss_index] <= mem_ins;
    end
  end

  logic unused_bits;
  assign unused_bits = &{1'b0, pc_from_if[1:0], mem_addr[1:0]};
`else
  assign hit      = 1'b0;
  assign hit_data = '0;

  logic unused_bits;
  assign unused_bits = &{1'b0, pc_from_if[1:0], mem_addr[1:0]};
`endif

  always_comb begin
    state_n     = state;
    ins_valid_n = 1'b0;
    ins_out_n   = ins_out;
    mem_req_n   = mem_req;
    mem_addr_n  = mem_addr;
    case (state)
      IDLE: begin
        mem_req_n = 1'b0;
        if (!flush && req_from_if) begin
          if (hit) begin
            ins_valid_n = 1'b1;
            ins_out_n   = hit_data;
            state_n     = RESP;
          end else begin
            mem_req_n  = 1'b1;
            mem_addr_n = {pc_from_if[31:2], 2'b00};
            state_n    = MISS;
          end
        end
      end
      MISS: begin
        if (mem_ok) begin
          mem_req_n = 1'b0;
          if (flush) begin
            state_n = IDLE;
          end else begin
            ins_valid_n = 1'b1;
            ins_out_n   = mem_ins;
            state_n     = RESP;
          end
        end else if (flush) begin
          mem_req_n = 1'b0;
          state_n   = IDLE;
        end
      end
      RESP: begin
        mem_req_n = 1'b0;
        state_n   = IDLE;
      end
      default: begin
        mem_req_n = 1'b0;
        state_n   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ins_valid <= 1'b0;
      ins_out   <= '0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
    end else if (rdy) begin
      state     <= state_n;
      ins_valid <= ins_valid_n;
      ins_out   <= ins_out_n;
      mem_req   <= mem_req_n;
      mem_addr  <= mem_addr_n;
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_ins_cache.sv
// Directed bench for ins_cache: a small reference cache model decides hit/miss,
// expected words go through a scoreboard queue and are popped on ins_valid.
module tb_ins_cache;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        req_from_if;
  logic [31:0] pc_from_if;
  logic        flush;
  logic        ins_valid;
  logic [31:0] ins_out;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ok;
  logic [31:0] mem_ins;
  logic [1:0]  state_dbg;

`ifdef ICACHE_EN
  localparam bit CACHE_EN = 1'b1;
`else
  localparam bit CACHE_EN = 1'b0;
`endif

  int vectors     = 0;
  int miscompares = 0;
  logic [31:0] exp_q[$];

  logic        m_valid [16];
  logic [25:0] m_tag   [16];
  logic [31:0] m_data  [16];

  ins_cache #(.LINES(16), .INDEX_W(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .req_from_if(req_from_if), .pc_from_if(pc_from_if), .flush(flush),
    .ins_valid(ins_valid), .ins_out(ins_out),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ok(mem_ok), .mem_ins(mem_ins),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_pop(input string tag);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_underflow"}, 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      check(tag, ins_out, e);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
  endtask

  task automatic model_fill(input logic [31:0] pc, input logic [31:0] ins);
    m_valid[pc[5:2]] = 1'b1;
    m_tag[pc[5:2]]   = pc[31:6];
    m_data[pc[5:2]]  = ins;
  endtask

  function automatic logic model_hit(input logic [31:0] pc);
    return CACHE_EN && m_valid[pc[5:2]] && (m_tag[pc[5:2]] == pc[31:6]);
  endfunction

  // Full fetch starting at a negedge with the DUT in IDLE; returns at a
  // negedge with the DUT back in IDLE.
  task automatic fetch(input logic [31:0] pc, input int lat, input logic [31:0] ins);
    logic hit;
    hit = model_hit(pc);
    req_from_if = 1'b1;
    pc_from_if  = pc;
    if (hit) exp_q.push_back(m_data[pc[5:2]]);
    @(negedge clk);
    if (hit) begin
      check("hit_valid", 32'(ins_valid), 32'd1);
      check_pop("hit_ins_out");
      check("hit_mem_req", 32'(mem_req), 32'd0);
    end else begin
      check("miss_mem_req", 32'(mem_req), 32'd1);
      check("miss_mem_addr", mem_addr, {pc[31:2], 2'b00});
      check("miss_no_valid", 32'(ins_valid), 32'd0);
      for (int i = 0; i < lat; i++) begin
        @(negedge clk);
        check("miss_hold_req", 32'(mem_req), 32'd1);
      end
      mem_ok  = 1'b1;
      mem_ins = ins;
      exp_q.push_back(ins);
      model_fill(pc, ins);
      @(negedge clk);
      mem_ok = 1'b0;
      check("fill_valid", 32'(ins_valid), 32'd1);
      check_pop("fill_ins_out");
      check("fill_mem_req_low", 32'(mem_req), 32'd0);
    end
    req_from_if = 1'b0;
    @(negedge clk);
    check("resp_valid_low", 32'(ins_valid), 32'd0);
    check("resp_back_idle", 32'(state_dbg), 32'd0);
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; req_from_if = 1'b0; pc_from_if = '0;
    flush = 1'b0; mem_ok = 1'b0; mem_ins = '0;
    model_clear();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_ins_valid", 32'(ins_valid), 32'd0);
    check("rst_ins_out", ins_out, 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);

    // Cold fetch, warm hit, index-4 conflict
    fetch(32'h0000_0010, 5, 32'h0010_0093);
    fetch(32'h0000_0010, 5, 32'h0010_0093);
    fetch(32'h0000_0050, 3, 32'h1234_5678);
    fetch(32'h0000_0010, 2, 32'h0010_0093);

    // Flush on the third MISS cycle aborts the controller request
    req_from_if = 1'b1; pc_from_if = 32'h0000_0020;
    @(negedge clk);
    check("fl_mid_req", 32'(mem_req), 32'd1);
    repeat (2) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; req_from_if = 1'b0;
    check("fl_mid_mem_req", 32'(mem_req), 32'd0);
    check("fl_mid_no_valid", 32'(ins_valid), 32'd0);
    check("fl_mid_state", 32'(state_dbg), 32'd0);
    @(negedge clk);
    check("fl_mid_no_valid2", 32'(ins_valid), 32'd0);
    fetch(32'h0000_0020, 1, 32'hAAAA_0001);

    // Flush coincident with mem_ok: no pulse, but the line is filled
    req_from_if = 1'b1; pc_from_if = 32'h0000_0030;
    @(negedge clk);
    check("fl_ok_req", 32'(mem_req), 32'd1);
    repeat (2) @(negedge clk);
    mem_ok = 1'b1; mem_ins = 32'hBBBB_0002; flush = 1'b1;
    model_fill(32'h0000_0030, 32'hBBBB_0002);
    @(negedge clk);
    mem_ok = 1'b0; flush = 1'b0; req_from_if = 1'b0;
    check("fl_ok_no_valid", 32'(ins_valid), 32'd0);
    check("fl_ok_mem_req", 32'(mem_req), 32'd0);
    check("fl_ok_state", 32'(state_dbg), 32'd0);
    @(negedge clk);
    check("fl_ok_no_valid2", 32'(ins_valid), 32'd0);
    fetch(32'h0000_0030, 2, 32'hBBBB_0002);

    // rdy low for four cycles while waiting on the controller
    req_from_if = 1'b1; pc_from_if = 32'h0000_0044;
    @(negedge clk);
    check("rdy_req", 32'(mem_req), 32'd1);
    rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rdy_frz_state", 32'(state_dbg), 32'd1);
      check("rdy_frz_addr", mem_addr, 32'h0000_0044);
      check("rdy_frz_req", 32'(mem_req), 32'd1);
    end
    rdy = 1'b1;
    repeat (2) @(negedge clk);
    mem_ok = 1'b1; mem_ins = 32'hCCCC_0003;
    exp_q.push_back(32'hCCCC_0003);
    model_fill(32'h0000_0044, 32'hCCCC_0003);
    @(negedge clk);
    mem_ok = 1'b0; req_from_if = 1'b0;
    check("rdy_fill_valid", 32'(ins_valid), 32'd1);
    check_pop("rdy_fill_ins_out");
    check("rdy_fill_req_low", 32'(mem_req), 32'd0);
    @(negedge clk);
    check("rdy_resp_low", 32'(ins_valid), 32'd0);

    // Flush together with a request in IDLE ignores the request
    req_from_if = 1'b1; flush = 1'b1; pc_from_if = 32'h0000_0100;
    @(negedge clk);
    req_from_if = 1'b0; flush = 1'b0;
    check("fl_idle_mem_req", 32'(mem_req), 32'd0);
    check("fl_idle_valid", 32'(ins_valid), 32'd0);
    check("fl_idle_state", 32'(state_dbg), 32'd0);

    // Reset during MISS: request dropped, nothing written, all lines invalid
    req_from_if = 1'b1; pc_from_if = 32'h0000_0060;
    @(negedge clk);
    check("rstm_req", 32'(mem_req), 32'd1);
    mem_ok = 1'b1; mem_ins = 32'hDEAD_BEEF; rst = 1'b1; flush = 1'b1;
    @(negedge clk);
    mem_ok = 1'b0; rst = 1'b0; flush = 1'b0; req_from_if = 1'b0;
    model_clear();
    check("rstm_mem_req", 32'(mem_req), 32'd0);
    check("rstm_valid", 32'(ins_valid), 32'd0);
    check("rstm_addr", mem_addr, 32'd0);
    check("rstm_state", 32'(state_dbg), 32'd0);
    fetch(32'h0000_0060, 1, 32'h6000_0006);
    fetch(32'h0000_0010, 1, 32'h0010_0093);

    // Random fetches over a small address window to mix hits and conflicts
    for (int i = 0; i < 12; i++) begin
      logic [31:0] rpc;
      rpc = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 3)) << 2);
      fetch(rpc, int'($urandom_range(0, 3)), $urandom);
    end

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
